// File: rtl/sha3_byte_packer.sv
// Byte-stream to 32-bit word packer feeding the SHA3-512 padder, with a small word FIFO.
// Optional byte-length counter output msg_len is enabled by defining SHA3_PACKER_LEN_EN.
module sha3_byte_packer #(
  parameter int DEPTH = 2,
  parameter int LEN_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  s_byte,
  input  logic        s_valid,
  input  logic        s_last,
  input  logic        s_flush,
  output logic        s_ready,
  output logic [31:0] w_data,
  output logic        w_ready,
  output logic        w_last,
  output logic [1:0]  w_byte_num,
  input  logic        buffer_full,
  output logic        done
`ifdef SHA3_PACKER_LEN_EN
  ,
  output logic [LEN_W-1:0] msg_len
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {FILL, PAD, DONE} state_t;

  state_t      state_reg, state_next;
  logic [23:0] hold_reg, hold_next;
  logic [1:0]  cnt_reg, cnt_next;

  // Each FIFO entry is {data[31:0], last, byte_num[1:0]}.
  logic [34:0]   mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;

  logic        fifo_full, fifo_empty;
  logic        byte_acc, flush_acc;
  logic        push, pop;
  logic [31:0] push_data, byte_word;
  logic        push_last;
  logic [1:0]  push_num;
  logic [34:0] head;

  assign fifo_full  = (count_reg == (AW+1)'(DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign s_ready    = !reset && (state_reg == FILL) && !fifo_full;
  assign byte_acc   = s_valid && s_ready;
  assign flush_acc  = s_flush && !s_valid && s_ready;
  assign pop        = !fifo_empty && !buffer_full;

  // Held bytes with the incoming byte dropped into the next free lane.
  always_comb begin
    byte_word = {hold_reg, 8'h00};
    case (cnt_reg)
      2'd0: byte_word[31:24] = s_byte;
      2'd1: byte_word[23:16] = s_byte;
      2'd2: byte_word[15:8]  = s_byte;
      default: byte_word[7:0] = s_byte;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    cnt_next   = cnt_reg;
    push       = 1'b0;
    push_data  = 32'h0;
    push_last  = 1'b0;
    push_num   = 2'd0;
    case (state_reg)
      FILL: begin
        if (byte_acc) begin
          if (!s_last && cnt_reg != 2'd3) begin
            hold_next = byte_word[31:8];
            cnt_next  = cnt_reg + 2'd1;
          end else begin
            push      = 1'b1;
            push_data = byte_word;
            hold_next = 24'h0;
            cnt_next  = 2'd0;
            if (s_last && cnt_reg != 2'd3) begin
              push_last  = 1'b1;
              push_num   = cnt_reg + 2'd1;
              state_next = DONE;
            end else if (s_last) begin
              state_next = PAD;
            end
          end
        end else if (flush_acc) begin
          push       = 1'b1;
          push_data  = {hold_reg, 8'h00};
          push_last  = 1'b1;
          push_num   = cnt_reg;
          hold_next  = 24'h0;
          cnt_next   = 2'd0;
          state_next = DONE;
        end
      end
      PAD: begin
        // A full final word still needs the core's all-padding terminator.
        if (!fifo_full) begin
          push       = 1'b1;
          push_last  = 1'b1;
          state_next = DONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= FILL;
      hold_reg   <= 24'h0;
      cnt_reg    <= 2'd0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
      cnt_reg   <= cnt_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= {push_data, push_last, push_num};
  end

  // An empty FIFO must never present is_last, since the core latches it.
  assign head       = fifo_empty ? 35'h0 : mem_reg[rd_ptr_reg];
  assign w_ready    = !fifo_empty;
  assign w_data     = head[34:3];
  assign w_last     = head[2];
  assign w_byte_num = head[1:0];
  assign done       = (state_reg == DONE) && fifo_empty;

`ifdef SHA3_PACKER_LEN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      msg_len <= '0;
    end else if (byte_acc && (msg_len != {LEN_W{1'b1}})) begin
      msg_len <= msg_len + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sha3_byte_packer.sv
// Directed self-checking bench for sha3_byte_packer (DEPTH=2).
module tb_sha3_byte_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  s_byte;
  logic        s_valid, s_last, s_flush;
  logic        s_ready;
  logic [31:0] w_data;
  logic        w_ready, w_last;
  logic [1:0]  w_byte_num;
  logic        buffer_full;
  logic        done;
`ifdef SHA3_PACKER_LEN_EN
  logic [31:0] msg_len;
`endif

  int errors = 0;
  int checks = 0;

  sha3_byte_packer #(.DEPTH(2), .LEN_W(32)) dut (
    .clk(clk), .reset(reset),
    .s_byte(s_byte), .s_valid(s_valid), .s_last(s_last), .s_flush(s_flush),
    .s_ready(s_ready),
    .w_data(w_data), .w_ready(w_ready), .w_last(w_last), .w_byte_num(w_byte_num),
    .buffer_full(buffer_full), .done(done)
`ifdef SHA3_PACKER_LEN_EN
    , .msg_len(msg_len)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] d, input logic l, input logic [1:0] n);
    $display("word %s: data=%h last=%0d num=%0d", tag, w_data, w_last, w_byte_num);
    chk({tag, ".ready"}, {31'h0, w_ready}, 32'h1);
    chk({tag, ".data"}, w_data, d);
    chk({tag, ".last"}, {31'h0, w_last}, {31'h0, l});
    chk({tag, ".num"}, {30'h0, w_byte_num}, {30'h0, n});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    s_valid = 1'b1;
    s_byte  = b;
    s_last  = last;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  logic [31:0] exp_data [4];
  logic        exp_last [4];
  int          i, k, cyc;

  initial begin
    reset = 1'b1; s_byte = 8'h0; s_valid = 1'b0; s_last = 1'b0; s_flush = 1'b0;
    buffer_full = 1'b0;
    tick(); tick();
    chk("rst.s_ready", {31'h0, s_ready}, 32'h0);
    chk("rst.w_ready", {31'h0, w_ready}, 32'h0);
    chk("rst.w_last", {31'h0, w_last}, 32'h0);
    chk("rst.w_num", {30'h0, w_byte_num}, 32'h0);
    chk("rst.w_data", w_data, 32'h0);
    chk("rst.done", {31'h0, done}, 32'h0);
    reset = 1'b0;
    #1;
    chk("rst.s_ready_after", {31'h0, s_ready}, 32'h1);

    // abc: one partial last word
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    send(8'h63, 1'b1);
    chk_word("abc", 32'h61626300, 1'b1, 2'd3);
    chk("abc.s_ready", {31'h0, s_ready}, 32'h0);
    chk("abc.done_early", {31'h0, done}, 32'h0);
    tick();
    chk("abc.empty", {31'h0, w_ready}, 32'h0);
    chk("abc.done", {31'h0, done}, 32'h1);
    chk("abc.last_idle", {31'h0, w_last}, 32'h0);
`ifdef SHA3_PACKER_LEN_EN
    chk("abc.msg_len", msg_len, 32'd3);
`endif

    // four bytes: full word then padding word via PAD
    do_reset();
    buffer_full = 1'b1;
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b1);
    chk_word("four.w0", 32'h01020304, 1'b0, 2'd0);
    tick();
    chk_word("four.hold", 32'h01020304, 1'b0, 2'd0);
    chk("four.done_early", {31'h0, done}, 32'h0);
    buffer_full = 1'b0;
    tick();
    chk_word("four.w1", 32'h00000000, 1'b1, 2'd0);
    tick();
    chk("four.empty", {31'h0, w_ready}, 32'h0);
    chk("four.done", {31'h0, done}, 32'h1);

    // empty message via flush
    do_reset();
    buffer_full = 1'b1;
    s_flush = 1'b1;
    tick();
    s_flush = 1'b0;
    chk_word("empty", 32'h00000000, 1'b1, 2'd0);
    buffer_full = 1'b0;
    tick();
    chk("empty.done", {31'h0, done}, 32'h1);

    // 12 bytes with backpressure
    do_reset();
    buffer_full = 1'b1;
    for (int b = 1; b <= 8; b++) send(8'(b), 1'b0);
    chk("bp.s_ready_low", {31'h0, s_ready}, 32'h0);
    chk_word("bp.head", 32'h01020304, 1'b0, 2'd0);
    s_valid = 1'b1; s_byte = 8'h09;
    tick(); tick(); tick();
    chk("bp.still_blocked", {31'h0, s_ready}, 32'h0);
    chk("bp.no_early_last", {31'h0, w_last}, 32'h0);
    exp_data[0] = 32'h01020304; exp_last[0] = 1'b0;
    exp_data[1] = 32'h05060708; exp_last[1] = 1'b0;
    exp_data[2] = 32'h090a0b0c; exp_last[2] = 1'b0;
    exp_data[3] = 32'h00000000; exp_last[3] = 1'b1;
    buffer_full = 1'b0;
    i = 8; k = 0; cyc = 0;
    while (!done && cyc < 60) begin
      if (i < 12) begin
        s_valid = 1'b1; s_byte = 8'(i + 1); s_last = (i == 11);
      end else begin
        s_valid = 1'b0; s_last = 1'b0;
      end
      if (s_ready && i < 12) i++;
      if (w_ready) begin
        if (k < 4) chk_word($sformatf("bp.w%0d", k), exp_data[k], exp_last[k], 2'd0);
        k++;
      end
      tick();
      cyc++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    chk("bp.word_count", k, 32'd4);
    chk("bp.done", {31'h0, done}, 32'h1);

    // valid and flush together: flush ignored
    do_reset();
    send(8'hAA, 1'b0);
    s_flush = 1'b1;
    send(8'hBB, 1'b0);
    s_flush = 1'b0;
    chk("vf.no_push", {31'h0, w_ready}, 32'h0);
    chk("vf.s_ready", {31'h0, s_ready}, 32'h1);
    send(8'hCC, 1'b1);
    chk_word("vf", 32'hAABBCC00, 1'b1, 2'd3);
    tick();

    // reset mid-message
    do_reset();
    buffer_full = 1'b1;
    for (int b = 1; b <= 5; b++) send(8'(b), 1'b0);
    chk("mid.queued", {31'h0, w_ready}, 32'h1);
    do_reset();
    chk("mid.w_ready", {31'h0, w_ready}, 32'h0);
    chk("mid.done", {31'h0, done}, 32'h0);
    chk("mid.s_ready", {31'h0, s_ready}, 32'h1);
    buffer_full = 1'b0;
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    chk_word("mid", 32'h11220000, 1'b1, 2'd2);
    tick();
    chk("mid.done_end", {31'h0, done}, 32'h1);
`ifdef SHA3_PACKER_LEN_EN
    chk("mid.msg_len", msg_len, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
